crc5_checker: RTL
=================

Name: crc5_checker

Overview:
- Serial CRC-5 checker; the receive-side counterpart of the team's serial CRC-5 generator.
- Generator polynomial is x^5 + x^3 + 1. The register is in direct (non-augmented) form and initialises to 5'b00000.
- Consumes a framed serial stream: DATA_BITS payload bits, then the 5 CRC bits sent MSB first (register bit 4 first).
- Reports pass/fail per frame, the residual syndrome, and a running error count.

Parameters:
- DATA_BITS, 5, payload bits per frame (>=1); frame length is DATA_BITS+5.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-high; clears all state.
- data  input  1  serial bit, sampled when valid=1.
- valid  input  1  data qualifier; bits with valid=0 are ignored and stall the frame.
- sof  input  1  start of frame; meaningful only with valid=1; marks the current bit as frame bit 0.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse at frame end.
- crc_ok  output  1  last frame passed; held until the next sof.
- crc_err  output  1  last frame failed; held until the next sof.
- syndrome  output  5  register contents after the last frame bit; held until the next sof.
- abort  output  1  one-cycle pulse when sof arrives mid-frame.
- err_count  output  ERR_CNT_W  failed frames since reset; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0, LFSR 00000, bit counter 0, FSM in IDLE.
- LFSR step on each accepted bit:
  - fb = lfsr[4]^data
  - lfsr[0] <= fb
  - lfsr[1] <= lfsr[0]
  - lfsr[2] <= lfsr[1]
  - lfsr[3] <= lfsr[2]^fb
  - lfsr[4] <= lfsr[3]
  - For a valid codeword the LFSR ends at 00000.
- States: IDLE, DATA, CHECK.
- IDLE:
  - valid&sof: step the LFSR from 00000 with data; counter=1; busy=1; crc_ok=crc_err=0.
  - Next state is DATA, or CHECK when DATA_BITS==... (see counter rule below).
  - valid without sof: ignored.
- DATA/CHECK:
  - Each valid bit steps the LFSR and increments the counter.
  - The state is CHECK once the counter reaches DATA_BITS. It is informational only; processing is identical.
- Frame end, at the edge accepting bit index DATA_BITS+4:
  - syndrome <= next LFSR value.
  - crc_ok <= (next==0); crc_err <= (next!=0).
  - frame_done pulses for the following cycle.
  - busy <= 0; return to IDLE.
  - err_count increments on error, saturating at all-ones.
- Latency: results are visible one cycle after the last bit is presented.
- Back-to-back frames: valid&sof in the cycle right after the last bit is accepted, because the FSM is already in IDLE.
- sof while busy (valid=1):
  - The current frame is discarded; abort pulses one cycle.
  - No frame_done; err_count is unchanged.
  - The LFSR restarts from 00000 with this bit; counter=1.
- valid=0 mid-frame: the LFSR, counter and state all hold. There is no timeout.
- Asynchronous reset mid-frame: immediate return to reset values. Partial frame state is lost and err_count clears.
- All outputs are registered; none are combinational from the inputs.

Test Plan:
- Good frame (DATA_BITS=5): bits 1,0,1,0,1,1,1,0,0,1 with sof on the first bit, valid always 1. Expect frame_done pulse, crc_ok=1, crc_err=0, syndrome=00000, err_count=0.
- Corrupt frame: same stream with the last bit 0 (1010111000). Expect crc_err=1, syndrome=01001, err_count=1.
- Gapped valid: good frame with valid=0 for 3 cycles between bits 4 and 5. Expect the same result as the good frame, with frame_done delayed 3 cycles.
- Mid-frame sof: 4 bits of a frame, then sof plus the good frame. Expect abort pulse, a single frame_done, crc_ok=1, err_count unchanged.
- Reset mid-frame: after 6 bits, pulse reset. Expect busy=0, all outputs 0 immediately; a following good frame passes.
- Saturation (ERR_CNT_W=2): 5 corrupt frames back-to-back. Expect err_count 1,2,3,3,3 and crc_err high after each frame.

Source files
------------

// File: rtl/crc5_checker.sv
// -----------------------------------------------------------------------------
// crc5_checker
//   Serial CRC-5 checker (polynomial x^5 + x^3 + 1, direct form, seed 00000).
//   Each frame is DATA_BITS payload bits followed by the 5 CRC bits, MSB
//   first. Feeding a whole valid frame through the register leaves 00000.
//   The block reports pass/fail and the residual syndrome for every frame, and
//   keeps a saturating count of failed frames.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, clears all state
//   data       in   serial bit, sampled when valid=1
//   valid      in   bit qualifier; valid=0 stalls the frame
//   sof        in   start of frame, qualified by valid; marks frame bit 0
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last frame bit is accepted
//   crc_ok     out  last frame passed, held until the next sof
//   crc_err    out  last frame failed, held until the next sof
//   syndrome   out  register contents after the last frame bit
//   abort      out  one-cycle pulse when sof restarts an unfinished frame
//   err_count  out  failed frames since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module crc5_checker #(
    parameter int DATA_BITS = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data,
    input  logic                 valid,
    input  logic                 sof,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic [4:0]           syndrome,
    output logic                 abort,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Counter holds the number of bits already accepted in the current frame.
    localparam int CNT_W = $clog2(DATA_BITS + 5) + 1;

    localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(32'd1);
    // Index of the payload/CRC boundary and of the final CRC bit.
    localparam logic [CNT_W-1:0]     DATA_IDX = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DATA_BITS + 4);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1'b1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // With a single payload bit the first accepted bit already finishes the payload.
    localparam state_t FIRST_STATE = (DATA_BITS == 1) ? ST_CHECK : ST_DATA;

    // One shift of the x^5 + x^3 + 1 register with the incoming bit.
    function automatic logic [4:0] crc5_step(input logic [4:0] cur, input logic din);
        logic fb;
        fb = cur[4] ^ din;
        return {cur[3], cur[2] ^ fb, cur[1], cur[0], fb};
    endfunction

    state_t           state_r;
    logic [4:0]       lfsr_r;
    logic [CNT_W-1:0] cnt_r;

    logic [4:0]       lfsr_next_s;
    logic [4:0]       lfsr_first_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Next-register candidates: continue the current frame or start a new one.
    always_comb begin
        lfsr_next_s  = crc5_step(lfsr_r, data);
        lfsr_first_s = crc5_step(5'b00000, data);
        cnt_inc_s    = cnt_r + CNT_ONE;
    end

    // Frame FSM, CRC register, bit counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= 5'b00000;
            cnt_r      <= CNT_ZERO;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            syndrome   <= 5'b00000;
            abort      <= 1'b0;
            err_count  <= {ERR_CNT_W{1'b0}};
        end else begin
            frame_done <= 1'b0;
            abort      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid && sof) begin
                        lfsr_r  <= lfsr_first_s;
                        cnt_r   <= CNT_ONE;
                        busy    <= 1'b1;
                        crc_ok  <= 1'b0;
                        crc_err <= 1'b0;
                        state_r <= FIRST_STATE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA, ST_CHECK: begin
                    if (valid) begin
                        if (sof) begin
                            // Restart: the unfinished frame is dropped without a verdict.
                            abort   <= 1'b1;
                            lfsr_r  <= lfsr_first_s;
                            cnt_r   <= CNT_ONE;
                            busy    <= 1'b1;
                            crc_ok  <= 1'b0;
                            crc_err <= 1'b0;
                            state_r <= FIRST_STATE;
                        end else if (cnt_r == LAST_IDX) begin
                            // This is the final CRC bit: publish the verdict.
                            syndrome   <= lfsr_next_s;
                            crc_ok     <= (lfsr_next_s == 5'b00000);
                            crc_err    <= (lfsr_next_s != 5'b00000);
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            lfsr_r     <= 5'b00000;
                            cnt_r      <= CNT_ZERO;
                            state_r    <= ST_IDLE;
                            if ((lfsr_next_s != 5'b00000) && (err_count != ERR_MAX)) begin
                                err_count <= err_count + ERR_ONE;
                            end else begin
                                err_count <= err_count;
                            end
                        end else begin
                            lfsr_r  <= lfsr_next_s;
                            cnt_r   <= cnt_inc_s;
                            state_r <= (cnt_inc_s >= DATA_IDX) ? ST_CHECK : ST_DATA;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    lfsr_r  <= 5'b00000;
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
